// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared FSM state type and default frame/burst constants for the frame-buffer arbiter
package fb_arb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_FRAME_WORDS = H_ACTIVE * V_ACTIVE;
  localparam int FB_BURST_LEN = 8;
endpackage

// File: rtl/fb_addr_track.sv
// fb_addr_track: per-side burst address counter with frame wrap, frame_done flag and restart
//   clk, rst_n   clock, async active-low reset
//   restart      frame-start pulse: address 0, frame_done cleared (beats advance)
//   advance      burst accepted on this side: address += BURST_LEN
//   addr         current burst start address
//   frame_done   set on wrap; blocks this side until restart
module fb_addr_track
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int BURST_LEN = FB_BURST_LEN,
  parameter int FRAME_WORDS = FB_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_done
);
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic done_d, done_q;
  logic [ADDR_W:0] nxt;
  logic wrap;
  always_comb begin
    nxt = {1'b0, addr_q} + (ADDR_W+1)'(BURST_LEN);
    wrap = nxt >= (ADDR_W+1)'(FRAME_WORDS);
    addr_d = restart ? '0 : advance ? (wrap ? '0 : nxt[ADDR_W-1:0]) : addr_q;
    done_d = !restart && (done_q || (advance && wrap));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      done_q <= done_d;
    end
  end
  assign addr = addr_q;
  assign frame_done = done_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port frame-buffer burst scheduler between capture writes and display reads
//   iCLK, iRST_N               clock, async active-low reset
//   iVS_START / iCAP_START     frame-start pulses restarting the read / write address
//   iRD_USED / iWR_USED        display read / capture write FIFO fill levels
//   iRD_REQ                    display consumes a word this cycle
//   oCMD_VALID/iCMD_READY      burst command handshake; oCMD_WRITE, oCMD_ADDR held while valid
//   iBURST_DONE                accepted burst has completed
//   oRD_BUSY / oWR_BUSY        read / write burst in flight
//   oUNDERRUN                  sticky underrun flag, built only with FB_ARB_UNDERRUN_EN
module vga_fb_arbiter
  import fb_arb_pkg::*;
#(
  parameter int BURST_LEN = FB_BURST_LEN,
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int ADDR_W = 22,
  parameter int FIFO_W = 10,
  parameter int RD_FIFO_DEPTH = 512,
  parameter int RD_LOW_WM = 128
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iVS_START,
  input  logic              iCAP_START,
  input  logic [FIFO_W-1:0] iRD_USED,
  input  logic [FIFO_W-1:0] iWR_USED,
  input  logic              iRD_REQ,
  output logic              oCMD_VALID,
  input  logic              iCMD_READY,
  output logic              oCMD_WRITE,
  output logic [ADDR_W-1:0] oCMD_ADDR,
  input  logic              iBURST_DONE,
  output logic              oRD_BUSY,
  output logic              oWR_BUSY,
  output logic              oUNDERRUN
);
  localparam logic [FIFO_W-1:0] RD_MAX = FIFO_W'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [FIFO_W-1:0] RD_LOW = FIFO_W'(RD_LOW_WM);
  localparam logic [FIFO_W-1:0] BL = FIFO_W'(BURST_LEN);
  state_t state_d, state_q;
  logic valid_d, valid_q, write_d, write_q, rd_busy_d, rd_busy_q, wr_busy_d, wr_busy_q;
  logic [ADDR_W-1:0] addr_d, addr_q, rd_addr, wr_addr;
  logic rd_done, wr_done, rd_elig, rd_urg, wr_elig, grant_rd, grant_wr, accept;
  fb_addr_track #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_rd (
    .clk(iCLK), .rst_n(iRST_N), .restart(iVS_START), .advance(accept && !write_q),
    .addr(rd_addr), .frame_done(rd_done)
  );
  fb_addr_track #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) u_wr (
    .clk(iCLK), .rst_n(iRST_N), .restart(iCAP_START), .advance(accept && write_q),
    .addr(wr_addr), .frame_done(wr_done)
  );
  // write_q always holds the type of the most recent grant, so it doubles as last_was_write
  always_comb begin
    rd_elig = !rd_done && iRD_USED <= RD_MAX;
    rd_urg = rd_elig && iRD_USED < RD_LOW;
    wr_elig = !wr_done && iWR_USED >= BL;
    grant_rd = state_q == IDLE && (rd_urg || (rd_elig && !(wr_elig && !write_q)));
    grant_wr = state_q == IDLE && wr_elig && !grant_rd;
    accept = state_q == CMD && iCMD_READY;
    state_d = (grant_rd || grant_wr) ? CMD : accept ? WAIT :
              (state_q == WAIT && iBURST_DONE) ? IDLE : state_q;
    write_d = grant_rd ? 1'b0 : grant_wr ? 1'b1 : write_q;
    addr_d = grant_rd ? rd_addr : grant_wr ? wr_addr : addr_q;
    valid_d = state_d == CMD;
    rd_busy_d = state_d != IDLE && !write_d;
    wr_busy_d = state_d != IDLE && write_d;
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      rd_busy_q <= 1'b0;
      wr_busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q <= addr_d;
      rd_busy_q <= rd_busy_d;
      wr_busy_q <= wr_busy_d;
    end
  end
  assign oCMD_VALID = valid_q;
  assign oCMD_WRITE = write_q;
  assign oCMD_ADDR = addr_q;
  assign oRD_BUSY = rd_busy_q;
  assign oWR_BUSY = wr_busy_q;
`ifdef FB_ARB_UNDERRUN_EN
  logic underrun_d, underrun_q;
  // frame start clears the flag even if an underrun is seen in the same cycle
  always_comb underrun_d = !iVS_START && (underrun_q || (iRD_REQ && iRD_USED == '0));
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) underrun_q <= 1'b0;
    else underrun_q <= underrun_d;
  end
  assign oUNDERRUN = underrun_q;
`else
  logic unused_rd_req;
  assign unused_rd_req = iRD_REQ;
  assign oUNDERRUN = 1'b0;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for vga_fb_arbiter with a 32-word frame
module tb_vga_fb_arbiter;
  logic iCLK, iRST_N, iVS_START, iCAP_START, iRD_REQ, iCMD_READY, iBURST_DONE;
  logic [9:0] iRD_USED, iWR_USED;
  logic oCMD_VALID, oCMD_WRITE, oRD_BUSY, oWR_BUSY, oUNDERRUN;
  logic [21:0] oCMD_ADDR;
  int tests = 0;
  int fails = 0;
  logic [22:0] sb[$];

  vga_fb_arbiter #(.FRAME_WORDS(32)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iVS_START(iVS_START), .iCAP_START(iCAP_START),
    .iRD_USED(iRD_USED), .iWR_USED(iWR_USED), .iRD_REQ(iRD_REQ),
    .oCMD_VALID(oCMD_VALID), .iCMD_READY(iCMD_READY), .oCMD_WRITE(oCMD_WRITE),
    .oCMD_ADDR(oCMD_ADDR), .iBURST_DONE(iBURST_DONE), .oRD_BUSY(oRD_BUSY),
    .oWR_BUSY(oWR_BUSY), .oUNDERRUN(oUNDERRUN)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  // every accepted command is matched against the next expected {write, addr}
  always @(negedge iCLK) begin
    if (iRST_N && oCMD_VALID && iCMD_READY) begin
      if (sb.size() == 0) chk("unexpected_cmd", {9'd0, oCMD_WRITE, oCMD_ADDR}, 32'hffff_ffff);
      else chk("cmd", {9'd0, oCMD_WRITE, oCMD_ADDR}, {9'd0, sb.pop_front()});
    end
  end

  // mode 1: frame start during WAIT; mode 2: frame start on the accepting cycle
  task automatic burst(input logic [9:0] rd_used, input logic [9:0] wr_used,
                       input logic exp_w, input logic [21:0] exp_a, input int stall, input int mode);
    sb.push_back({exp_w, exp_a});
    iRD_USED = rd_used;
    iWR_USED = wr_used;
    chk("pre_valid", oCMD_VALID, 0);
    tick;
    iRD_USED = 10'd510;
    iWR_USED = 10'd0;
    chk("grant_valid", oCMD_VALID, 1);
    chk("grant_busy", exp_w ? oWR_BUSY : oRD_BUSY, 1);
    for (int i = 0; i < stall; i++) begin
      iBURST_DONE = (i == 1);
      tick;
      chk("stall_valid", oCMD_VALID, 1);
      chk("stall_addr", oCMD_ADDR, exp_a);
      chk("stall_write", oCMD_WRITE, exp_w);
    end
    iBURST_DONE = 1'b0;
    iCMD_READY = 1'b1;
    iVS_START = (mode == 2);
    tick;
    iCMD_READY = 1'b0;
    iVS_START = 1'b0;
    chk("wait_valid", oCMD_VALID, 0);
    chk("wait_busy", exp_w ? oWR_BUSY : oRD_BUSY, 1);
    if (mode == 1) begin
      iVS_START = 1'b1;
      tick;
      iVS_START = 1'b0;
      chk("vs_wait_busy", oRD_BUSY, 1);
    end
    iBURST_DONE = 1'b1;
    tick;
    iBURST_DONE = 1'b0;
    chk("idle_busy", {30'd0, oRD_BUSY, oWR_BUSY}, 0);
  endtask

  task automatic no_grant(input logic [9:0] rd_used, input logic [9:0] wr_used);
    iRD_USED = rd_used;
    iWR_USED = wr_used;
    repeat (3) tick;
    chk("no_grant", oCMD_VALID, 0);
    iRD_USED = 10'd510;
    iWR_USED = 10'd0;
  endtask

  initial begin
    iRST_N = 1'b0;
    iVS_START = 1'b0;
    iCAP_START = 1'b0;
    iRD_REQ = 1'b0;
    iCMD_READY = 1'b0;
    iBURST_DONE = 1'b0;
    iRD_USED = 10'd510;
    iWR_USED = 10'd0;
    repeat (3) tick;
    chk("rst_valid", oCMD_VALID, 0);
    chk("rst_write", oCMD_WRITE, 0);
    chk("rst_addr", oCMD_ADDR, 0);
    chk("rst_busy", {30'd0, oRD_BUSY, oWR_BUSY}, 0);
    chk("rst_underrun", oUNDERRUN, 0);
    iRST_N = 1'b1;
    tick;
    burst(300, 8, 1, 0, 0, 0);
    burst(100, 64, 0, 0, 0, 0);
    burst(300, 64, 1, 8, 0, 0);
    burst(300, 64, 0, 8, 0, 0);
    burst(300, 64, 1, 16, 0, 0);
    burst(300, 64, 0, 16, 0, 0);
    burst(300, 0, 0, 24, 0, 0);
    no_grant(300, 0);
    iVS_START = 1'b1;
    tick;
    iVS_START = 1'b0;
    burst(300, 0, 0, 0, 5, 1);
    burst(300, 0, 0, 0, 0, 2);
    burst(300, 0, 0, 0, 0, 0);
    burst(510, 8, 1, 24, 0, 0);
    no_grant(510, 64);
    iCAP_START = 1'b1;
    tick;
    iCAP_START = 1'b0;
    burst(510, 8, 1, 0, 0, 0);
    burst(300, 64, 0, 8, 0, 0);
    iRD_USED = 10'd100;
    tick;
    iRD_USED = 10'd510;
    chk("mid_valid", oCMD_VALID, 1);
    iRST_N = 1'b0;
    #1;
    chk("mid_rst_valid", oCMD_VALID, 0);
    chk("mid_rst_addr", oCMD_ADDR, 0);
    chk("mid_rst_busy", oRD_BUSY, 0);
    tick;
    iRST_N = 1'b1;
    tick;
    burst(300, 8, 1, 0, 0, 0);
    burst(300, 64, 0, 0, 0, 0);
`ifdef FB_ARB_UNDERRUN_EN
    chk("ur_pre", oUNDERRUN, 0);
    iRD_REQ = 1'b1;
    iRD_USED = 10'd0;
    tick;
    chk("ur_set", oUNDERRUN, 1);
    iRD_REQ = 1'b0;
    iRD_USED = 10'd510;
    repeat (2) tick;
    chk("ur_hold", oUNDERRUN, 1);
    iRD_REQ = 1'b1;
    iRD_USED = 10'd0;
    iVS_START = 1'b1;
    tick;
    iVS_START = 1'b0;
    iRD_REQ = 1'b0;
    chk("ur_clear", oUNDERRUN, 0);
`else
    iRD_REQ = 1'b1;
    iRD_USED = 10'd0;
    tick;
    iRD_REQ = 1'b0;
    chk("ur_tied", oUNDERRUN, 0);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
